// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment display data path.
package seg_pkg;

  localparam int unsigned DATA_W              = 20;
  localparam int unsigned DIGITS              = 6;
  localparam int unsigned TICK_CYCLES_DEFAULT = 5_000_000;
  localparam int unsigned DATA_MAX_DEFAULT    = 999_999;

  localparam logic [DIGITS-1:0] POINT_NONE = 6'b000000;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [DIGITS-1:0] point_t;

endpackage

// File: rtl/data_gen_if.sv
// Display-value bundle handed from data_gen to the seg_dynamic/BCD stage.
interface data_gen_if;
  import seg_pkg::*;

  data_t  data;
  point_t point;
  logic   sign;
  logic   seg_en;

  modport master (output data, output point, output sign, output seg_en);
  modport slave  (input  data, input  point, input  sign, input  seg_en);

endinterface

// File: rtl/data_gen_tick_gen.sv
// Prescaler producing a registered one-cycle tick every TICK_CYCLES clocks.
module tick_gen #(
  parameter int unsigned TICK_CYCLES = 5_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_CYCLES);

  logic [CNT_W-1:0] cnt_tick;

  // Free-running modulo-TICK_CYCLES counter; tick is high while cnt_tick sits at its last value.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_tick <= '0;
      tick     <= 1'b0;
    end else begin
      if (cnt_tick == CNT_W'(TICK_CYCLES - 1)) begin
        cnt_tick <= '0;
      end else begin
        cnt_tick <= cnt_tick + CNT_W'(1);
      end
      tick <= (cnt_tick == CNT_W'(TICK_CYCLES - 2));
    end
  end

endmodule

// File: rtl/data_gen.sv
// Decimal display value generator: counts 0..DATA_MAX, one step per tick.
module data_gen
  import seg_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = TICK_CYCLES_DEFAULT,
  parameter int unsigned DATA_MAX    = DATA_MAX_DEFAULT
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  data_gen_if.master disp
);

  logic tick;

  tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .tick   (tick)
  );

  // Display registers: count with wrap on tick, constant controls after reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      disp.data   <= '0;
      disp.point  <= '0;
      disp.sign   <= 1'b0;
      disp.seg_en <= 1'b0;
    end else begin
      disp.point  <= POINT_NONE;
      disp.sign   <= 1'b0;
      disp.seg_en <= 1'b1;
      if (tick) begin
        if (disp.data == DATA_W'(DATA_MAX)) begin
          disp.data <= '0;
        end else begin
          disp.data <= disp.data + DATA_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_data_gen.sv
// Bench for data_gen: three parameterisations driven with random resets,
// checked every cycle against an edge-count model of the display value.
module tb_data_gen;
  import seg_pkg::*;

  localparam int unsigned NDUT = 3;
  localparam int unsigned TC [NDUT] = '{10, 4, 5_000_000};
  localparam int unsigned MX [NDUT] = '{15, 15, 999_999};

  logic            sys_clk;
  logic [NDUT-1:0] rst;

  int unsigned checks;
  int unsigned errors;

  // Edges since the last reset edge (0 right after a reset edge).
  int unsigned n [NDUT];

  data_gen_if if_a ();
  data_gen_if if_b ();
  data_gen_if if_c ();

  data_gen #(.TICK_CYCLES(10), .DATA_MAX(15)) dut_a (
    .sys_clk(sys_clk), .sys_rst(rst[0]), .disp(if_a.master));
  data_gen #(.TICK_CYCLES(4), .DATA_MAX(15)) dut_b (
    .sys_clk(sys_clk), .sys_rst(rst[1]), .disp(if_b.master));
  data_gen dut_c (
    .sys_clk(sys_clk), .sys_rst(rst[2]), .disp(if_c.master));

  data_t  d_obs [NDUT];
  point_t p_obs [NDUT];
  logic   s_obs [NDUT];
  logic   e_obs [NDUT];
  logic   t_obs [NDUT];

  assign d_obs[0] = if_a.data;   assign p_obs[0] = if_a.point;
  assign s_obs[0] = if_a.sign;   assign e_obs[0] = if_a.seg_en;
  assign d_obs[1] = if_b.data;   assign p_obs[1] = if_b.point;
  assign s_obs[1] = if_b.sign;   assign e_obs[1] = if_b.seg_en;
  assign d_obs[2] = if_c.data;   assign p_obs[2] = if_c.point;
  assign s_obs[2] = if_c.sign;   assign e_obs[2] = if_c.seg_en;
  assign t_obs[0] = dut_a.u_tick_gen.tick;
  assign t_obs[1] = dut_b.u_tick_gen.tick;
  assign t_obs[2] = dut_c.u_tick_gen.tick;

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    bit mid_done;
    checks   = 0;
    errors   = 0;
    mid_done = 1'b0;
    rst      = '1;
    for (int k = 0; k < NDUT; k++) n[k] = 0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge sys_clk);
      for (int k = 0; k < NDUT; k++) begin
        if (rst[k]) n[k] = 0;
        else        n[k] = n[k] + 1;
      end

      @(negedge sys_clk);
      for (int k = 0; k < NDUT; k++) begin
        int unsigned exp_data;
        string nm;
        nm = (k == 0) ? "a" : (k == 1) ? "b" : "c";
        exp_data = (n[k] / TC[k]) % (MX[k] + 1);
        check({nm, "_data"},   32'(d_obs[k]), exp_data);
        check({nm, "_seg_en"}, 32'(e_obs[k]), (n[k] > 0) ? 1 : 0);
        check({nm, "_point"},  32'(p_obs[k]), 32'(POINT_NONE));
        check({nm, "_sign"},   32'(s_obs[k]), 0);
        check({nm, "_tick"},   32'(t_obs[k]), (n[k] % TC[k] == TC[k] - 1) ? 1 : 0);
        if (d_obs[k] > data_t'(MX[k])) check({nm, "_data_range"}, 32'(d_obs[k]), MX[k]);
      end

      // Release after 3 reset cycles; one directed reset of A while data=5 and
      // its tick is high; then sparse random resets on each instance.
      if (cyc < 2) begin
        rst = '1;
      end else if (cyc < 400) begin
        rst = '0;
        if (!mid_done && n[0] == 59) begin
          rst[0]   = 1'b1;
          mid_done = 1'b1;
        end
      end else begin
        for (int k = 0; k < NDUT; k++) rst[k] = ($urandom_range(0, 299) == 0);
      end
    end

    check("mid_reset_hit", 32'(mid_done), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
